// File: rtl/mac_pkg.sv
// mac_pkg
// Shared definitions for the result write-port arbiter: FSM state encoding,
// requester port indices and the default data width.
package mac_pkg;

    localparam int   MAC_DATA_W = 32;

    localparam logic PORT_CORE  = 1'b0;
    localparam logic PORT_MAC   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

endpackage

// File: rtl/mac_port_arbiter_mux.sv
// MUX_2_by_1
// Plain 2:1 data mux, shared by the write-port arbiter.
// Ports:
//   s  - select; 0 passes a, 1 passes b
//   a  - input 0
//   b  - input 1
//   y  - selected data
module MUX_2_by_1 #(
    parameter int W = 32
) (
    input  logic         s,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mac_port_arbiter.sv
// mac_port_arbiter
// Round-robin arbiter sharing one result write port between the core
// writeback (port 0) and the matrix MAC unit (port 1). Bursts end on `last`
// or are cut after MAX_HOLD beats when the other side is waiting. Accepted
// beats are registered into a one-entry output stage.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   reqK_valid/data/last/ready    - requester K beat handshake (K = 0, 1)
//   out_valid/data/src/last       - registered output beat
//   out_ready                     - downstream accepts output beat
//   sel                           - data mux select (1 only in GRANT1)
//   busy                          - FSM not in IDLE
//
// state  | meaning
// IDLE   | no grant; arbitrating among valid requesters
// GRANT0 | port 0 (core) owns the write port
// GRANT1 | port 1 (MAC) owns the write port
module mac_port_arbiter
    import mac_pkg::*;
#(
    parameter int DATA_W   = MAC_DATA_W,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam int             CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD);

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       cnt_inc;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_src_q, out_src_d;
    logic                out_last_q, out_last_d;

    logic                stall;
    logic                accept;
    logic                grant_port;
    logic                own_valid;
    logic                own_last;
    logic                other_valid;
    logic                release_grant;
    logic [DATA_W-1:0]   mux_data;

    MUX_2_by_1 #(.W(DATA_W)) u_data_mux (
        .s (sel),
        .a (req0_data),
        .b (req1_data),
        .y (mux_data)
    );

    assign sel        = (state_q == GRANT1);
    assign busy       = (state_q != IDLE);
    assign stall      = out_valid_q && !out_ready;
    assign req0_ready = (state_q == GRANT0) && !stall;
    assign req1_ready = (state_q == GRANT1) && !stall;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Granted side's view of the request lines; only meaningful in GRANTx.
    assign grant_port  = (state_q == GRANT1) ? PORT_MAC : PORT_CORE;
    assign own_valid   = grant_port ? req1_valid : req0_valid;
    assign own_last    = grant_port ? req1_last  : req0_last;
    assign other_valid = grant_port ? req0_valid : req1_valid;
    assign cnt_inc     = cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        release_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_d = ptr_q ? GRANT1 : GRANT0;
                end else if (req0_valid) begin
                    state_d = GRANT0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (!stall) begin
                    if (own_valid) begin
                        if (own_last || ((cnt_inc == HOLD_LIM) && other_valid)) begin
                            release_grant = 1'b1;
                        end else if (cnt_inc == HOLD_LIM) begin
                            // Nobody waiting: wrap the count and keep the grant.
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Requester went quiet: treat it as end of burst.
                        release_grant = 1'b1;
                    end
                    if (release_grant) begin
                        ptr_d = ~grant_port;
                        cnt_d = '0;
                        // Updated pointer favours the other side, so check it first.
                        if (other_valid) begin
                            state_d = grant_port ? GRANT0 : GRANT1;
                        end else if (own_valid) begin
                            state_d = state_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_src_d   = grant_port;
            out_last_d  = own_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PORT_CORE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;

endmodule
